// File: rtl/trace_packer.sv
// Packs one DATA_WIDTH sample per cycle into N-lane vectors for the trace input buffer.
// Closes a vector on the N-th lane, on a frame end, or when tracing stops with a partial vector.
module trace_packer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tracing,
    input  logic                             sample_valid,
    input  logic [DATA_WIDTH-1:0]            sample_in,
    input  logic                             sample_eof,
    output logic                             enqueue,
    output logic                             eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic [15:0]                      frame_count
);

    localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [N-1:0][DATA_WIDTH-1:0]     acc_q, acc_d;
    logic [N-1:0][DATA_WIDTH-1:0]     merged;
    logic [N-1:0][DATA_WIDTH-1:0]     vec_q, vec_d;
    logic                             enq_q, enq_d;
    logic                             eof_q, eof_d;
    logic [15:0]                      fc_q, fc_d;

    logic accept;
    logic flush;
    logic emit;

    assign accept = tracing && sample_valid;
    assign flush  = !tracing && (idx_q != '0);
    assign emit   = flush || (accept && (sample_eof || (idx_q == LAST_IDX)));

    // Accumulator with the incoming sample dropped into its lane. Lanes above
    // idx are still zero from the last clear, so this is already zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign merged[gi] = (accept && (idx_q == IDX_W'(gi))) ? sample_in : acc_q[gi];
        end
    endgenerate

    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        vec_d = vec_q;
        enq_d = 1'b0;
        eof_d = eof_q;
        fc_d  = fc_q;
        if (emit) begin
            idx_d = '0;
            acc_d = '0;
            vec_d = merged;
            enq_d = 1'b1;
            eof_d = flush || sample_eof;
            if ((flush || sample_eof) && (fc_q != 16'hFFFF)) begin
                fc_d = fc_q + 16'd1;
            end
        end else if (accept) begin
            idx_d = idx_q + IDX_W'(1);
            acc_d = merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
            vec_q <= '0;
            enq_q <= 1'b0;
            eof_q <= 1'b0;
            fc_q  <= 16'd0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
            vec_q <= vec_d;
            enq_q <= enq_d;
            eof_q <= eof_d;
            fc_q  <= fc_d;
        end
    end

    assign enqueue     = enq_q;
    assign eof_out     = eof_q;
    assign vector_out  = vec_q;
    assign frame_count = fc_q;

endmodule
